wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 106 ++++++++++
 tb/tb_wb_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer between the load/ALU result paths and
// the register file write port, with forwarding lookup over the pending entries.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ld_valid/ld_rd/ld_data          load-result writeback request
//   alu_valid/alu_rd/alu_data       ALU-result writeback request
//   stall                           fewer than two entries free
//   A3/WD3/WE3                      register file write port (head entry)
//   q_a1/q_a2                       forwarding lookup addresses
//   fwd1_hit/fwd1_data, fwd2_*      youngest pending match for each lookup
//   count                           number of valid entries
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    input  logic [4:0]                 ld_rd,
    input  logic [31:0]                ld_data,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       stall,
    output logic [4:0]                 A3,
    output logic [31:0]                WD3,
    output logic                       WE3,
    input  logic [4:0]                 q_a1,
    input  logic [4:0]                 q_a2,
    output logic                       fwd1_hit,
    output logic [31:0]                fwd1_data,
    output logic                       fwd2_hit,
    output logic [31:0]                fwd2_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] MAXC = (AW+1)'(DEPTH - 2);

    logic [4:0]    rd_q [DEPTH];
    logic [4:0]    rd_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, alu_slot;
    logic [AW:0]   count_q, count_d;
    logic          push_ld, push_alu, pop;

    assign stall    = count_q > MAXC;
    assign push_ld  = ld_valid && ld_rd != 5'd0 && !stall;
    assign push_alu = alu_valid && alu_rd != 5'd0 && !stall;
    assign pop      = count_q != '0;
    assign WE3      = pop;
    assign A3       = pop ? rd_q[head_q] : 5'd0;
    assign WD3      = pop ? data_q[head_q] : 32'd0;
    assign count    = count_q;

    // ld takes the tail slot first so it is older than a same-cycle alu entry
    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        alu_slot = tail_q + AW'(push_ld);
        if (push_ld) begin
            rd_d[tail_q]   = ld_rd;
            data_d[tail_q] = ld_data;
        end
        if (push_alu) begin
            rd_d[alu_slot]   = alu_rd;
            data_d[alu_slot] = alu_data;
        end
        head_d  = head_q + AW'(pop);
        tail_d  = alu_slot + AW'(push_alu);
        count_d = count_q + (AW+1)'(push_ld) + (AW+1)'(push_alu) - (AW+1)'(pop);
    end

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count_q && q_a1 != 5'd0 && rd_q[head_q + AW'(i)] == q_a1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = data_q[head_q + AW'(i)];
            end
            if ((AW+1)'(i) < count_q && q_a2 != 5'd0 && rd_q[head_q + AW'(i)] == q_a2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = data_q[head_q + AW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed vector table plus random traffic against a queue model
// of the pending writebacks; every register file write is popped from the model.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]  ld_rd = '0, alu_rd = '0, q_a1 = '0, q_a2 = '0;
    logic [31:0] ld_data = '0, alu_data = '0;
    logic        stall, WE3, fwd1_hit, fwd2_hit;
    logic [4:0]  A3;
    logic [31:0] WD3, fwd1_data, fwd2_data;
    logic [2:0]  count;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .stall(stall), .A3(A3), .WD3(WD3), .WE3(WE3),
        .q_a1(q_a1), .q_a2(q_a2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int lv; int lr; logic [31:0] ld;
        int av; int ar; logic [31:0] ad;
        int a1; int a2;
        int cnt; int stl; int we; int a3; logic [31:0] wd;
        int f1h; logic [31:0] f1d; int f2h;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[14];
    int   checks = 0;
    int   failures = 0;
    logic stall_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare all outputs against the queue model's view of pending entries
    task automatic mcheck();
        logic        h1, h2;
        logic [31:0] d1, d2;
        h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
        foreach (sb[i]) begin
            if (q_a1 != 0 && sb[i].rd == q_a1) begin h1 = 1'b1; d1 = sb[i].data; end
            if (q_a2 != 0 && sb[i].rd == q_a2) begin h2 = 1'b1; d2 = sb[i].data; end
        end
        stall_m = (DEPTH - sb.size()) < 2;
        chk("count", 32'(count), 32'(sb.size()));
        chk("stall", 32'(stall), 32'(stall_m));
        chk("we3", 32'(WE3), 32'(sb.size() > 0));
        chk("a3", 32'(A3), sb.size() > 0 ? 32'(sb[0].rd) : 32'd0);
        chk("wd3", WD3, sb.size() > 0 ? sb[0].data : 32'd0);
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h1));
        chk("fwd1_data", fwd1_data, d1);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h2));
        chk("fwd2_data", fwd2_data, d2);
    endtask

    // Clock edge: the head retires, accepted requests join the model
    task automatic adv();
        @(posedge clk);
        if (sb.size() > 0) void'(sb.pop_front());
        if (!stall_m && ld_valid && ld_rd != 0) sb.push_back('{ld_rd, ld_data});
        if (!stall_m && alu_valid && alu_rd != 0) sb.push_back('{alu_rd, alu_data});
        @(negedge clk);
    endtask

    task automatic idle();
        ld_valid = 1'b0; alu_valid = 1'b0; ld_rd = '0; alu_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0,0,32'h0, 1,5,32'hDEADBEEF, 5,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[1]  = '{0,0,32'h0, 0,0,32'h0, 5,0, 1,0,1,5,32'hDEADBEEF, 1,32'hDEADBEEF,0};
        vecs[2]  = '{0,0,32'h0, 0,0,32'h0, 5,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[3]  = '{1,3,32'h11, 1,3,32'h22, 3,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[4]  = '{0,0,32'h0, 0,0,32'h0, 3,0, 2,0,1,3,32'h11, 1,32'h22,0};
        vecs[5]  = '{0,0,32'h0, 0,0,32'h0, 3,0, 1,0,1,3,32'h22, 1,32'h22,0};
        vecs[6]  = '{0,0,32'h0, 1,0,32'h55, 0,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[7]  = '{0,0,32'h0, 0,0,32'h0, 0,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[8]  = '{1,1,32'hA1, 1,2,32'hA2, 0,0, 0,0,0,0,32'h0, 0,32'h0,0};
        vecs[9]  = '{1,3,32'hB1, 1,4,32'hB2, 1,0, 2,0,1,1,32'hA1, 1,32'hA1,0};
        vecs[10] = '{1,5,32'hC1, 1,6,32'hC2, 6,2, 3,1,1,2,32'hA2, 0,32'h0,1};
        vecs[11] = '{0,0,32'h0, 0,0,32'h0, 4,0, 2,0,1,3,32'hB1, 1,32'hB2,0};
        vecs[12] = '{0,0,32'h0, 0,0,32'h0, 6,0, 1,0,1,4,32'hB2, 0,32'h0,0};
        vecs[13] = '{0,0,32'h0, 0,0,32'h0, 0,0, 0,0,0,0,32'h0, 0,32'h0,0};

        // Reset state, held across a clock edge
        @(posedge clk);
        #1;
        mcheck();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; first entry is accepted on the first edge out of reset
        for (int i = 0; i < 14; i++) begin
            ld_valid = 1'(vecs[i].lv); ld_rd = 5'(vecs[i].lr); ld_data = vecs[i].ld;
            alu_valid = 1'(vecs[i].av); alu_rd = 5'(vecs[i].ar); alu_data = vecs[i].ad;
            q_a1 = 5'(vecs[i].a1); q_a2 = 5'(vecs[i].a2);
            #1;
            mcheck();
            chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.stall", i), 32'(stall), 32'(vecs[i].stl));
            chk($sformatf("v%0d.we3", i), 32'(WE3), 32'(vecs[i].we));
            chk($sformatf("v%0d.a3", i), 32'(A3), 32'(vecs[i].a3));
            chk($sformatf("v%0d.wd3", i), WD3, vecs[i].wd);
            chk($sformatf("v%0d.fwd1_hit", i), 32'(fwd1_hit), 32'(vecs[i].f1h));
            chk($sformatf("v%0d.fwd1_data", i), fwd1_data, vecs[i].f1d);
            chk($sformatf("v%0d.fwd2_hit", i), 32'(fwd2_hit), 32'(vecs[i].f2h));
            adv();
        end

        // Random traffic with a narrow rd range to exercise matches and stalls
        for (int n = 0; n < 300; n++) begin
            ld_valid = 1'($urandom_range(0, 1)); ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            q_a1 = 5'($urandom_range(0, 7)); q_a2 = 5'($urandom_range(0, 7));
            #1;
            mcheck();
            adv();
        end
        idle();
        for (int n = 0; n < 4; n++) begin
            #1;
            mcheck();
            adv();
        end

        // Fill to three entries, then reset between clock edges
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h71;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h81;
        #1; mcheck(); adv();
        ld_rd = 5'd9; ld_data = 32'h91; alu_rd = 5'd10; alu_data = 32'hA0;
        #1; mcheck(); adv();
        idle();
        q_a1 = 5'd9; q_a2 = 5'd10;
        #1;
        chk("pre_rst.count", 32'(count), 32'd3);
        chk("pre_rst.stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.we3", 32'(WE3), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("rst.fwd2_hit", 32'(fwd2_hit), 32'd0);
        chk("rst.a3", 32'(A3), 32'd0);
        chk("rst.wd3", WD3, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        mcheck();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            mcheck();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
